// File: rtl/oflow_score_board_pkg.sv
// ---------------------------------------------------------------------------
// oflow_score_board_pkg : shared types and constants for the score board
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

// Fallback widths when the core define file has not been read first.
`ifndef SCORE_LEN
`define SCORE_LEN 12
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif

package oflow_score_board_pkg;

  localparam int C_SCORE_W = `SCORE_LEN;
  localparam int C_ID_W    = `ID_LEN;

  localparam logic [C_SCORE_W-1:0] C_SCORE_INVALID = '1;
  localparam logic [C_ID_W-1:0]    C_ID_NULL       = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic                 claim_valid;
    logic                 is_new;
    logic [1:0]           attempt;
    logic [C_ID_W-1:0]    claimed_id;
    logic [C_SCORE_W-1:0] claimed_score;
    logic [C_SCORE_W-1:0] score0;
    logic [C_ID_W-1:0]    id0;
    logic [C_SCORE_W-1:0] score1;
    logic [C_ID_W-1:0]    id1;
  } entry_t;

  function automatic logic cand_valid(input logic [C_SCORE_W-1:0] score,
                                      input logic [C_ID_W-1:0]    id);
    return (id != C_ID_NULL) && (score != C_SCORE_INVALID);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oflow_score_board_fifo.sv
// ---------------------------------------------------------------------------
// oflow_score_board_fifo : synchronous FIFO with flush, full and empty flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oflow_score_board_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
  endfunction

  assign full      = (r_count == C_CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + C_CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/oflow_score_board.sv
// ---------------------------------------------------------------------------
// oflow_score_board : resolves previous-ID claims between current objects,
// allocates new IDs and streams the final assignment.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oflow_score_board
  import oflow_score_board_pkg::*;
#(
  parameter int MAX_OBJ    = 32,
  parameter int IDX_LEN    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_frame,
  input  logic [IDX_LEN:0]     num_objects,
  input  logic [C_ID_W-1:0]    new_id_base,
  input  logic                 done_score_calc,
  input  logic [IDX_LEN-1:0]   cur_idx,
  input  logic [C_SCORE_W-1:0] min_score_0,
  input  logic [C_SCORE_W-1:0] min_score_1,
  input  logic [C_ID_W-1:0]    min_id_0,
  input  logic [C_ID_W-1:0]    min_id_1,
  output logic                 busy,
  output logic                 fifo_overflow,
  output logic                 out_valid,
  output logic [IDX_LEN-1:0]   out_cur_idx,
  output logic [C_ID_W-1:0]    out_id,
  output logic                 out_is_new,
  output logic [C_ID_W-1:0]    next_new_id,
  output logic                 done_score_board
);

  localparam int C_ITEM_W = IDX_LEN + 2 * C_SCORE_W + 2 * C_ID_W;
  localparam int C_CNT_W  = IDX_LEN + 1;

  state_e               r_state;
  state_e               w_state_nx;
  logic [IDX_LEN-1:0]   r_emit_idx;
  logic [IDX_LEN-1:0]   w_emit_nx;
  logic [C_CNT_W-1:0]   r_num;
  logic [C_CNT_W-1:0]   r_arrivals;
  entry_t               r_table [MAX_OBJ];
  logic                 r_pend_valid;
  logic [IDX_LEN-1:0]   r_pend_idx;

  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [C_ITEM_W-1:0]  w_push_item;
  logic [C_ITEM_W-1:0]  w_head_item;
  logic [IDX_LEN-1:0]   w_head_idx;
  logic [C_SCORE_W-1:0] w_head_s0;
  logic [C_SCORE_W-1:0] w_head_s1;
  logic [C_ID_W-1:0]    w_head_id0;
  logic [C_ID_W-1:0]    w_head_id1;

  logic                 w_step;
  logic                 w_resolved;
  logic [IDX_LEN-1:0]   w_work_idx;
  logic [C_SCORE_W-1:0] w_s0;
  logic [C_SCORE_W-1:0] w_s1;
  logic [C_ID_W-1:0]    w_id0;
  logic [C_ID_W-1:0]    w_id1;
  logic [1:0]           w_att;
  logic [C_SCORE_W-1:0] w_cand_score;
  logic [C_ID_W-1:0]    w_cand_id;
  logic                 w_owner_hit;
  logic [IDX_LEN-1:0]   w_owner_idx;
  logic                 w_win;

  assign w_push_item = {cur_idx, min_score_0, min_id_0, min_score_1, min_id_1};
  assign {w_head_idx, w_head_s0, w_head_id0, w_head_s1, w_head_id1} = w_head_item;
  assign w_fifo_push = done_score_calc && !start_frame;
  assign w_fifo_pop  = w_step && !r_pend_valid;

  oflow_score_board_fifo #(
    .WIDTH (C_ITEM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset_N),
    .flush     (start_frame),
    .push      (w_fifo_push),
    .push_data (w_push_item),
    .pop       (w_fifo_pop),
    .head_data (w_head_item),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // One resolve step: pick the work item, skip unusable candidates, find owner.
  always_comb begin
    w_step      = (r_state == ST_RESOLVE) && !start_frame && (r_pend_valid || !w_fifo_empty);
    w_resolved  = (r_arrivals == r_num) && w_fifo_empty && !r_pend_valid;
    w_work_idx  = r_pend_valid ? r_pend_idx : w_head_idx;
    w_s0        = w_head_s0;
    w_id0       = w_head_id0;
    w_s1        = w_head_s1;
    w_id1       = w_head_id1;
    w_att       = 2'd0;
    if (r_pend_valid) begin
      w_s0  = r_table[r_pend_idx].score0;
      w_id0 = r_table[r_pend_idx].id0;
      w_s1  = r_table[r_pend_idx].score1;
      w_id1 = r_table[r_pend_idx].id1;
      w_att = r_table[r_pend_idx].attempt;
    end
    if (w_att == 2'd0 && !cand_valid(w_s0, w_id0)) w_att = 2'd1;
    if (w_att == 2'd1 && !cand_valid(w_s1, w_id1)) w_att = 2'd2;
    w_cand_score = (w_att == 2'd0) ? w_s0  : w_s1;
    w_cand_id    = (w_att == 2'd0) ? w_id0 : w_id1;

    w_owner_hit = 1'b0;
    w_owner_idx = '0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      if (!w_owner_hit && r_table[i].claim_valid &&
          r_table[i].claimed_id == w_cand_id && IDX_LEN'(i) != w_work_idx) begin
        w_owner_hit = 1'b1;
        w_owner_idx = IDX_LEN'(i);
      end
    end
    w_win = w_owner_hit && (w_cand_score < r_table[w_owner_idx].claimed_score);
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      for (int i = 0; i < MAX_OBJ; i++) r_table[i] <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_idx    <= '0;
      r_arrivals    <= '0;
      r_num         <= '0;
      next_new_id   <= '0;
      fifo_overflow <= 1'b0;
    end else if (start_frame) begin
      for (int i = 0; i < MAX_OBJ; i++) r_table[i] <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_idx    <= '0;
      r_arrivals    <= '0;
      r_num         <= num_objects;
      next_new_id   <= new_id_base;
      fifo_overflow <= 1'b0;
    end else begin
      if (w_fifo_push && w_fifo_full && !w_fifo_pop) fifo_overflow <= 1'b1;
      if (w_step) begin
        if (!r_pend_valid) begin
          r_table[w_work_idx].score0 <= w_s0;
          r_table[w_work_idx].id0    <= w_id0;
          r_table[w_work_idx].score1 <= w_s1;
          r_table[w_work_idx].id1    <= w_id1;
          r_arrivals                 <= r_arrivals + C_CNT_W'(1);
        end
        if (w_att == 2'd2) begin
          // Fresh IDs carry score 0 so no later claimant can displace them.
          r_table[w_work_idx].claim_valid   <= 1'b1;
          r_table[w_work_idx].claimed_id    <= next_new_id;
          r_table[w_work_idx].claimed_score <= '0;
          r_table[w_work_idx].is_new        <= 1'b1;
          r_table[w_work_idx].attempt       <= 2'd2;
          next_new_id                       <= next_new_id + C_ID_W'(1);
          r_pend_valid                      <= 1'b0;
        end else if (!w_owner_hit || w_win) begin
          r_table[w_work_idx].claim_valid   <= 1'b1;
          r_table[w_work_idx].claimed_id    <= w_cand_id;
          r_table[w_work_idx].claimed_score <= w_cand_score;
          r_table[w_work_idx].is_new        <= 1'b0;
          r_table[w_work_idx].attempt       <= w_att;
          if (w_owner_hit) begin
            r_table[w_owner_idx].claim_valid <= 1'b0;
            r_table[w_owner_idx].attempt     <= r_table[w_owner_idx].attempt + 2'd1;
            r_pend_valid                     <= 1'b1;
            r_pend_idx                       <= w_owner_idx;
          end else begin
            r_pend_valid <= 1'b0;
          end
        end else begin
          r_table[w_work_idx].attempt <= w_att + 2'd1;
          r_pend_valid                <= 1'b1;
          r_pend_idx                  <= w_work_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_emit_nx  = r_emit_idx;
    if (start_frame) begin
      w_state_nx = ST_RESOLVE;
      w_emit_nx  = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nx = ST_IDLE;
        ST_RESOLVE: begin
          if (w_resolved) begin
            w_emit_nx  = '0;
            w_state_nx = (r_num == '0) ? ST_DONE : ST_EMIT;
          end
        end
        ST_EMIT: begin
          if ({1'b0, r_emit_idx} == r_num - C_CNT_W'(1)) w_state_nx = ST_DONE;
          else                                            w_emit_nx  = r_emit_idx + IDX_LEN'(1);
        end
        ST_DONE: w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_state          <= ST_IDLE;
      r_emit_idx       <= '0;
      busy             <= 1'b0;
      out_valid        <= 1'b0;
      out_cur_idx      <= '0;
      out_id           <= '0;
      out_is_new       <= 1'b0;
      done_score_board <= 1'b0;
    end else begin
      r_state          <= w_state_nx;
      r_emit_idx       <= w_emit_nx;
      busy             <= (w_state_nx == ST_RESOLVE) || (w_state_nx == ST_EMIT);
      out_valid        <= (w_state_nx == ST_EMIT);
      out_cur_idx      <= (w_state_nx == ST_EMIT) ? w_emit_nx : '0;
      out_id           <= (w_state_nx == ST_EMIT) ? r_table[w_emit_nx].claimed_id : '0;
      out_is_new       <= (w_state_nx == ST_EMIT) && r_table[w_emit_nx].is_new;
      done_score_board <= (w_state_nx == ST_DONE);
    end
  end

endmodule

`default_nettype wire

// File: doc/oflow_score_board.md
# oflow_score_board

Downstream consumer of the per-object score calculation. Each time a score-calc unit finishes a current-frame object, it reports two candidates: a best (min_score_0 / min_id_0) and a runner-up (min_score_1 / min_id_1) previous-frame ID. This block resolves conflicts where several current objects claim the same previous ID, and allocates fresh IDs to unmatched objects. Once all objects have reported, it streams the final ID assignment to registration.

## Interface
Parameters:
- MAX_OBJ, 32, maximum number of current-frame objects per frame.
- IDX_LEN, 5, width of a current-object index (log2 MAX_OBJ).
- FIFO_DEPTH, 4, depth of the input result FIFO.

Ports:
- clk  in  1  single clock.
- reset_N  in  1  asynchronous, active-high reset.
- start_frame  in  1  one-cycle pulse. Clears all state and loads num_objects and new_id_base.
- num_objects  in  IDX_LEN+1  object count for this frame (0..MAX_OBJ).
- new_id_base  in  `ID_LEN  first ID available for new objects.
- done_score_calc  in  1  one-cycle pulse: the result for cur_idx is valid.
- cur_idx  in  IDX_LEN  current-object index of the reported result.
- min_score_0 / min_score_1  in  `SCORE_LEN each  best / runner-up score.
- min_id_0 / min_id_1  in  `ID_LEN each  best / runner-up previous-frame ID.
- busy  out  1  high from start_frame until done_score_board.
- fifo_overflow  out  1  sticky; cleared by start_frame.
- out_valid  out  1  assignment-stream valid.
- out_cur_idx  out  IDX_LEN  object index of the current assignment.
- out_id  out  `ID_LEN  ID assigned to that object.
- out_is_new  out  1  set when out_id was freshly allocated.
- next_new_id  out  `ID_LEN  next unallocated ID.
- done_score_board  out  1  one-cycle pulse after the last assignment.

## Operation
- **Per-object table.** MAX_OBJ entries, each holding {claim_valid, claimed_id, claimed_score, attempt (0..2), score0, id0, score1, id1}.
- **Candidate validity.** A candidate is invalid if its ID is 0 or its score is all-ones. An invalid candidate is skipped, and the attempt advances.
- **Arrival.**
  - done_score_calc pushes {cur_idx, scores, IDs} into the FIFO.
  - When the FSM pops an item, it writes that entry's score and ID fields and sets attempt=0.
  - Each cur_idx arrives exactly once per frame. Duplicates are not detected.
- **Resolve step (one per cycle).**
  - The work item is the pending displaced index if one is held, otherwise the FIFO head.
  - The candidate is selected by attempt: 0 uses the best pair, 1 uses the runner-up pair, 2 allocates a new ID.
  - The candidate ID is compared in parallel against the claimed_id of every other entry with claim_valid set.
  - No owner: claim it.
  - Owner exists and new score is strictly lower: the work item claims the ID. The owner's claim_valid is cleared, its attempt is incremented, and it becomes the pending item.
  - Owner exists and new score is greater or equal: the work item's attempt is incremented and it stays as the work item for the next cycle.
  - Attempt 2: claimed_id = next_new_id, next_new_id increments, and the entry is marked new. This step always succeeds.
  - Every chain terminates within 2·num_objects steps.
- **FSM states.**
  - IDLE. start_frame moves to RESOLVE.
  - RESOLVE. Moves to EMIT when arrivals == num_objects, the FIFO is empty, and no item is pending or in progress.
  - EMIT. Streams out_cur_idx 0..num_objects-1, one per cycle.
  - DONE. Pulses done_score_board for one cycle, then returns to IDLE.
- **Priority.** start_frame has priority over everything. It aborts any state, clears the table, FIFO and flags, and a simultaneous done_score_calc is dropped.
- **FIFO full.** Push and pop in the same cycle is allowed. A push into a full FIFO with no pop is dropped and sets fifo_overflow.

## Timing
- **Reset values.** All outputs are 0. The FSM is in IDLE and the table and FIFO are empty.
- **Input latency.** A result pushed in cycle t can begin resolving in cycle t+1 at the earliest.
- **Resolve rate.** One resolve step per cycle.
- **Table update.** Claims update the table at the clock edge that ends the step.
- **Zero objects.** With num_objects=0, start_frame at t gives RESOLVE at t+1, done_score_board at t+2, and no out_valid.
- **EMIT.** out_valid is high for exactly num_objects consecutive cycles. done_score_board follows the last of them in the next cycle.
- **Output registration.** Outputs are registered. out_* hold 0 when out_valid is low.

## Structure
- Shared package oflow_score_board_pkg:
  - FSM state enum.
  - Entry struct.
  - Invalid-score constant (all-ones `SCORE_LEN).
  - Null ID constant 0.
- `SCORE_LEN and `ID_LEN come from the existing core define file.
- One sub-module: oflow_score_board_fifo, a parameterised synchronous FIFO with full/empty flags.

## Test plan
- **Distinct IDs.** num_objects=2. Obj0 (10,id5 / 20,id6), obj1 (15,id7 / 30,id8) → outputs {0,5,new=0}, {1,7,new=0}, then done.
- **Displacement.** Obj0 (30,id5 / 40,id6), then obj1 (10,id5 / 50,id8) → obj1 gets 5, obj0 falls to 6.
- **Tie.** Two objects both at (10,id5 / 20,id9) → first arrival keeps 5, second gets 9.
- **New ID.** new_id_base=100. Obj1 loses both candidates, and another object has id0=0 → both receive new IDs 100 and 101, out_is_new=1, next_new_id=102.
- **Overflow.** FIFO_DEPTH+2 back-to-back pulses during a long displacement chain → fifo_overflow=1, dropped items are never emitted, and the flag clears on start_frame.
- **Abort and reset.** start_frame during EMIT → stream stops next cycle and no done pulse. Separately, reset_N asserted mid-RESOLVE → all outputs 0 asynchronously.
